// File: rtl/bram_stream_pkg.sv
// Shared constants and FSM encoding for bram_stream_ctrl.
// BRAM_OUT_REG_EN selects the 2-cycle BRAM read latency (registered douta).
package bram_stream_pkg;

   localparam int unsigned DW    = 16;
   localparam int unsigned AW    = 6;
   localparam int unsigned DEPTH = 2 ** AW;

`ifdef BRAM_OUT_REG_EN
   localparam int unsigned RD_LAT = 2;
`else
   localparam int unsigned RD_LAT = 1;
`endif

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      READ,
      DRAIN
   } state_e;

endpackage

// File: rtl/bram_stream_ctrl_if.sv
// Write stream, read stream, command and BRAM port A signals of bram_stream_ctrl.
// BRAM_OUT_REG_EN affects only the timing of bram_douta, not this bundle.
interface bram_stream_ctrl_if;
   import bram_stream_pkg::*;

   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          s_last;
   logic [AW-1:0] wr_base;
   logic          rd_start;
   logic [AW-1:0] rd_base;
   logic [AW:0]   rd_len;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          busy;
   logic          done;
   logic [AW-1:0] bram_addra;
   logic [DW-1:0] bram_dina;
   logic          bram_wea;
   logic [DW-1:0] bram_douta;

   modport master (
      input  s_valid, s_data, s_last, wr_base, rd_start, rd_base, rd_len, m_ready, bram_douta,
      output s_ready, m_valid, m_data, m_last, busy, done, bram_addra, bram_dina, bram_wea
   );

   modport slave (
      output s_valid, s_data, s_last, wr_base, rd_start, rd_base, rd_len, m_ready, bram_douta,
      input  s_ready, m_valid, m_data, m_last, busy, done, bram_addra, bram_dina, bram_wea
   );

endinterface

// File: rtl/bram_rd_fifo.sv
// Small synchronous ring-buffer FIFO holding returned BRAM words plus their last flag.
// Depth is independent of BRAM_OUT_REG_EN; the caller sizes it for the read latency.
module bram_rd_fifo #(
   parameter int unsigned Width = 17,
   parameter int unsigned Depth = 4,
   localparam int unsigned CntW = $clog2(Depth + 1),
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic [CntW-1:0]  count_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wptr_q, wptr_d;
   logic [PtrW-1:0]  rptr_q, rptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   always_comb begin
      do_pop  = pop_i && (count_q != '0);
      // A pop frees the head slot, so a push into a full FIFO is legal in the same cycle.
      do_push = push_i && ((count_q != CntW'(Depth)) || do_pop);
      wptr_d  = do_push ? ptr_inc(wptr_q) : wptr_q;
      rptr_d  = do_pop ? ptr_inc(rptr_q) : rptr_q;
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/bram_stream_ctrl.sv
// Loads a valid/ready stream into a 64x16 BRAM and streams runs of words back out.
// Define BRAM_OUT_REG_EN when the BRAM output register is enabled (2-cycle read latency).
module bram_stream_ctrl
   import bram_stream_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input logic                clk,
   input logic                rst,
   bram_stream_ctrl_if.master bus
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned LW = AW + 1;

   state_e            state_q, state_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     rem_q, rem_d;
   logic [CW-1:0]     credit_q, credit_d;
   logic              done_q, done_d;
   logic [RD_LAT-1:0] tag_vld_q, tag_last_q;

   logic              issue, issue_last, pop, push, fifo_empty;
   logic [AW-1:0]     issue_addr;
   logic [DW:0]       fifo_rdata;
   logic [CW-1:0]     fifo_count;

   assign fifo_empty  = (fifo_count == '0);
   assign pop         = ~fifo_empty & bus.m_ready;
   assign push        = tag_vld_q[RD_LAT-1];
   assign bus.m_valid = ~fifo_empty;
   assign bus.m_data  = fifo_empty ? '0 : fifo_rdata[DW-1:0];
   assign bus.m_last  = ~fifo_empty & fifo_rdata[DW];
   assign bus.busy    = (state_q != IDLE);
   assign bus.done    = done_q;

   always_comb begin
      state_d        = state_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      rem_d          = rem_q;
      done_d         = 1'b0;
      issue          = 1'b0;
      issue_last     = 1'b0;
      issue_addr     = rd_ptr_q;
      bus.s_ready    = 1'b0;
      bus.bram_wea   = 1'b0;
      bus.bram_addra = '0;
      bus.bram_dina  = '0;

      unique case (state_q)
         IDLE: begin
            bus.s_ready = ~rst;
            if (bus.s_valid && !rst) begin
               bus.bram_wea   = 1'b1;
               bus.bram_addra = bus.wr_base;
               bus.bram_dina  = bus.s_data;
               wr_ptr_d       = bus.wr_base + AW'(1);
               if (bus.s_last) begin
                  done_d = 1'b1;
               end else begin
                  state_d = LOAD;
               end
            end else if (bus.rd_start && !rst) begin
               // First read goes out with the command so data returns one cycle earlier.
               state_d  = READ;
               rem_d    = bus.rd_len;
               rd_ptr_d = bus.rd_base;
               if (bus.rd_len != '0) begin
                  issue      = 1'b1;
                  issue_addr = bus.rd_base;
                  issue_last = (bus.rd_len == LW'(1));
                  rem_d      = bus.rd_len - LW'(1);
                  rd_ptr_d   = bus.rd_base + AW'(1);
               end
            end
         end
         LOAD: begin
            bus.s_ready = 1'b1;
            if (bus.s_valid) begin
               bus.bram_wea   = 1'b1;
               bus.bram_addra = wr_ptr_q;
               bus.bram_dina  = bus.s_data;
               wr_ptr_d       = wr_ptr_q + AW'(1);
               if (bus.s_last) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         READ: begin
            if (rem_q == '0) begin
               // Only reached on entry: rd_len of 0 (nothing in flight) or 1 (already issued).
               if (credit_q == '0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = DRAIN;
               end
            end else if (credit_q < CW'(FIFO_DEPTH)) begin
               issue      = 1'b1;
               issue_addr = rd_ptr_q;
               issue_last = (rem_q == LW'(1));
               rd_ptr_d   = rd_ptr_q + AW'(1);
               rem_d      = rem_q - LW'(1);
               if (rem_q == LW'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pop && bus.m_last) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (issue) begin
         bus.bram_addra = issue_addr;
      end
      // Credits cover words in the BRAM pipeline plus words parked in the FIFO.
      credit_d = credit_q + CW'(issue) - CW'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         rem_q      <= '0;
         credit_q   <= '0;
         done_q     <= 1'b0;
         tag_vld_q  <= '0;
         tag_last_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rem_q      <= rem_d;
         credit_q   <= credit_d;
         done_q     <= done_d;
         tag_vld_q  <= RD_LAT'({tag_vld_q, issue});
         tag_last_q <= RD_LAT'({tag_last_q, issue_last});
      end
   end

   bram_rd_fifo #(
      .Width (DW + 1),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i ({tag_last_q[RD_LAT-1], bus.bram_douta}),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count)
   );

endmodule

// File: tb/tb_bram_stream_ctrl.sv
// Directed bench for bram_stream_ctrl with a behavioural 64x16 BRAM on port A.
// BRAM_OUT_REG_EN adds the BRAM output register stage to the model.
module tb_bram_stream_ctrl;
   import bram_stream_pkg::*;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   logic [DW-1:0] shadow [DEPTH];
   logic [DW-1:0] bram_mem [DEPTH];
   logic [DW-1:0] dout_s1;

   bram_stream_ctrl_if bus ();

   bram_stream_ctrl #(
      .FIFO_DEPTH (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Read-first single-port RAM model
   always @(posedge clk) begin
      if (bus.bram_wea) bram_mem[bus.bram_addra] <= bus.bram_dina;
      dout_s1 <= bram_mem[bus.bram_addra];
   end

`ifdef BRAM_OUT_REG_EN
   logic [DW-1:0] dout_s2;
   always @(posedge clk) dout_s2 <= dout_s1;
   assign bus.bram_douta = dout_s2;
`else
   assign bus.bram_douta = dout_s1;
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, required completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [AW-1:0] base, input int n, input logic [DW-1:0] first,
                       input logic [DW-1:0] step, input string tag);
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      for (int i = 0; i < n; i++) begin
         a = base + AW'(i);
         d = first + DW'(i) * step;
         bus.s_valid = 1'b1;
         bus.s_data  = d;
         bus.s_last  = (i == n - 1);
         bus.wr_base = base;
         @(negedge clk);
         check({tag, "_sready"}, 32'(bus.s_ready), 1);
         check({tag, "_wea"}, 32'(bus.bram_wea), 1);
         check({tag, "_addr"}, 32'(bus.bram_addra), 32'(a));
         check({tag, "_dina"}, 32'(bus.bram_dina), 32'(d));
         shadow[a] = d;
         tick();
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      @(negedge clk);
      check({tag, "_done"}, 32'(bus.done), 1);
      check({tag, "_busy"}, 32'(bus.busy), 0);
      check({tag, "_wea_off"}, 32'(bus.bram_wea), 0);
      tick();
   endtask

   task automatic run_read(input logic [AW-1:0] base, input logic [AW:0] len, input int mode,
                           input string tag);
      int            k;
      int            dones;
      logic          stalled;
      logic [DW-1:0] held_d;
      logic          held_l;
      logic [AW-1:0] a;
      k       = 0;
      dones   = 0;
      stalled = 1'b0;
      held_d  = '0;
      held_l  = 1'b0;
      for (int cyc = 0; cyc < 1000 && dones == 0; cyc++) begin
         bus.rd_start = (cyc == 0);
         bus.rd_base  = base;
         bus.rd_len   = len;
         bus.m_ready  = (mode == 0) || (cyc % 3 == 0);
         @(negedge clk);
         check({tag, "_fifo_bound"}, 32'(dut.u_fifo.count_o > 3'd4), 0);
         if (stalled) begin
            check({tag, "_hold_valid"}, 32'(bus.m_valid), 1);
            check({tag, "_hold_data"}, 32'(bus.m_data), 32'(held_d));
            check({tag, "_hold_last"}, 32'(bus.m_last), 32'(held_l));
         end
         if (bus.m_valid && bus.m_ready) begin
            if (k < int'(len)) begin
               a = base + AW'(k);
               check({tag, "_data"}, 32'(bus.m_data), 32'(shadow[a]));
               check({tag, "_last"}, 32'(bus.m_last), 32'(k == int'(len) - 1));
            end else begin
               check({tag, "_extra_word"}, 32'(bus.m_valid), 0);
            end
            k++;
         end
         stalled = bus.m_valid && !bus.m_ready;
         held_d  = bus.m_data;
         held_l  = bus.m_last;
         if (bus.done) dones++;
         tick();
      end
      bus.rd_start = 1'b0;
      bus.m_ready  = 1'b1;
      check({tag, "_words"}, 32'(k), 32'(len));
      check({tag, "_done"}, 32'(dones), 1);
      @(negedge clk);
      check({tag, "_done_once"}, 32'(bus.done), 0);
      check({tag, "_idle"}, 32'(bus.busy), 0);
      check({tag, "_mvalid_off"}, 32'(bus.m_valid), 0);
      tick();
   endtask

   initial begin
      logic [DW-1:0] vals [4];
      int            dones;
      vals    = '{16'd1, 16'd2, 16'd3, 16'd4};
      n_tests = 0;
      n_fail  = 0;
      rst          = 1'b1;
      bus.s_valid  = 1'b0;
      bus.s_data   = '0;
      bus.s_last   = 1'b0;
      bus.wr_base  = '0;
      bus.rd_start = 1'b0;
      bus.rd_base  = '0;
      bus.rd_len   = '0;
      bus.m_ready  = 1'b0;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_sready", 32'(bus.s_ready), 0);
      check("rst_mvalid", 32'(bus.m_valid), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_wea", 32'(bus.bram_wea), 0);
      check("rst_addr", 32'(bus.bram_addra), 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("idle_sready", 32'(bus.s_ready), 1);
      check("idle_busy", 32'(bus.busy), 0);
      tick();

      // Single-word load at address 2
      load(6'd2, 1, 16'h3f80, 16'd0, "w1");
      @(negedge clk);
      check("w1_done_pulse", 32'(bus.done), 0);
      tick();

      // Four words wrapping 62,63,0,1 then read back with no backpressure
      load(6'd62, 4, 16'd1, 16'd1, "w4");
      bus.m_ready  = 1'b1;
      bus.rd_start = 1'b1;
      bus.rd_base  = 6'd62;
      bus.rd_len   = 7'd4;
      @(negedge clk);
      check("r4_c0_mvalid", 32'(bus.m_valid), 0);
      check("r4_c0_sready", 32'(bus.s_ready), 1);
      tick();
      bus.rd_start = 1'b0;
      for (int c = 0; c < int'(RD_LAT); c++) begin
         @(negedge clk);
         check("r4_lat_mvalid", 32'(bus.m_valid), 0);
         check("r4_lat_busy", 32'(bus.busy), 1);
         check("r4_lat_sready", 32'(bus.s_ready), 0);
         tick();
      end
      for (int w = 0; w < 4; w++) begin
         @(negedge clk);
         check("r4_mvalid", 32'(bus.m_valid), 1);
         check("r4_data", 32'(bus.m_data), 32'(vals[w]));
         check("r4_last", 32'(bus.m_last), 32'(w == 3));
         tick();
      end
      @(negedge clk);
      check("r4_done", 32'(bus.done), 1);
      check("r4_mvalid_off", 32'(bus.m_valid), 0);
      check("r4_busy_off", 32'(bus.busy), 0);
      tick();

      // Same run with m_ready pattern 1,0,0 repeating
      run_read(6'd62, 7'd4, 1, "bp");

      // Full 64-word load of index values, then full-depth read
      load(6'd0, 64, 16'd0, 16'd1, "w64");
      run_read(6'd0, 7'd64, 0, "r64");

      // Write and read command together: write wins
      bus.s_valid  = 1'b1;
      bus.s_data   = 16'h00aa;
      bus.s_last   = 1'b1;
      bus.wr_base  = 6'd5;
      bus.rd_start = 1'b1;
      bus.rd_base  = 6'd0;
      bus.rd_len   = 7'd3;
      @(negedge clk);
      check("coll_wea", 32'(bus.bram_wea), 1);
      check("coll_addr", 32'(bus.bram_addra), 5);
      check("coll_dina", 32'(bus.bram_dina), 32'h00aa);
      shadow[5] = 16'h00aa;
      tick();
      bus.s_valid  = 1'b0;
      bus.s_last   = 1'b0;
      bus.rd_start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("coll_mvalid", 32'(bus.m_valid), 0);
         check("coll_busy", 32'(bus.busy), 0);
         check("coll_done", 32'(bus.done), 32'(c == 0));
         tick();
      end

      // Zero-length read: one done pulse, never m_valid
      bus.rd_start = 1'b1;
      bus.rd_len   = 7'd0;
      @(negedge clk);
      tick();
      bus.rd_start = 1'b0;
      dones = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("len0_mvalid", 32'(bus.m_valid), 0);
         if (c == 0) check("len0_busy", 32'(bus.busy), 1);
         if (bus.done) dones++;
         tick();
      end
      check("len0_dones", 32'(dones), 1);

      run_read(6'd5, 7'd1, 0, "one");

      // Reset in the middle of a read after two words
      bus.m_ready  = 1'b1;
      bus.rd_start = 1'b1;
      bus.rd_base  = 6'd62;
      bus.rd_len   = 7'd4;
      tick();
      bus.rd_start = 1'b0;
      repeat (RD_LAT) tick();
      @(negedge clk);
      check("rr_w0", 32'(bus.m_data), 62);
      tick();
      @(negedge clk);
      check("rr_w1", 32'(bus.m_data), 63);
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("rr_mvalid", 32'(bus.m_valid), 0);
      check("rr_mdata", 32'(bus.m_data), 0);
      check("rr_busy", 32'(bus.busy), 0);
      check("rr_done", 32'(bus.done), 0);
      check("rr_sready", 32'(bus.s_ready), 0);
      tick();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("rr_post_done", 32'(bus.done), 0);
         check("rr_post_mvalid", 32'(bus.m_valid), 0);
         check("rr_post_busy", 32'(bus.busy), 0);
         tick();
      end
      run_read(6'd62, 7'd4, 0, "rerun");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
